// File: rtl/transmitter_if.sv
// Start/data handshake and serial frame outputs of the word transmitter.
interface transmitter_if;
  logic        start;
  logic [31:0] txdata;
  logic        ready;
  logic        busy;
  logic        done;
  logic        dataout;
  logic        comEn;
  logic        sclk;

  modport master (
    output start, txdata,
    input  ready, busy, done, dataout, comEn, sclk
  );

  modport slave (
    input  start, txdata,
    output ready, busy, done, dataout, comEn, sclk
  );
endinterface

// File: rtl/transmitter.sv
// Serialises a 32-bit word MSB first with a bit clock and frame enable,
// followed by an idle gap of GAP_BITS bit periods before the next word.
module transmitter #(
  parameter int HALF_DIV = 50,
  parameter int GAP_BITS = 2
) (
  input logic clk,
  input logic reset,
  transmitter_if.slave bus
);

  localparam int BIT_CYCLES = 2 * (HALF_DIV + 1);
  localparam int GAP_CYCLES = GAP_BITS * BIT_CYCLES;
  localparam int DIV_W      = $clog2(BIT_CYCLES);
  localparam int GAP_W      = $clog2(GAP_CYCLES);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(HALF_DIV + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [4:0]       BIT_LAST = 5'd31;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t           state, state_next;
  logic [31:0]      shift_reg, shift_next;
  logic [4:0]       bit_cnt, bit_next;
  logic [DIV_W-1:0] div_cnt, div_next;
  logic [GAP_W-1:0] gap_cnt, gap_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_cnt   <= bit_next;
      div_cnt   <= div_next;
      gap_cnt   <= gap_next;
    end
  end

  always_comb begin
    state_next = state;
    shift_next = shift_reg;
    bit_next   = bit_cnt;
    div_next   = div_cnt;
    gap_next   = gap_cnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = SHIFT;
          shift_next = bus.txdata;
          bit_next   = '0;
          div_next   = '0;
        end
      end
      SHIFT: begin
        if (div_cnt != DIV_LAST) begin
          div_next = div_cnt + 1'b1;
        end else if (bit_cnt != BIT_LAST) begin
          div_next   = '0;
          bit_next   = bit_cnt + 1'b1;
          shift_next = {shift_reg[30:0], 1'b0};
        end else begin
          state_next = GAP;
          div_next   = '0;
          gap_next   = '0;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = IDLE;
        end else begin
          gap_next = gap_cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The gap counter is zero only on the first GAP cycle, which marks the end of the word.
  assign bus.ready   = (state == IDLE);
  assign bus.busy    = (state != IDLE);
  assign bus.comEn   = (state == SHIFT);
  assign bus.dataout = (state == SHIFT) && shift_reg[31];
  assign bus.sclk    = (state == SHIFT) && (div_cnt >= DIV_HALF);
  assign bus.done    = (state == GAP) && (gap_cnt == '0);

endmodule

// File: tb/tb_transmitter.sv
// Randomised scoreboard bench: a small-divider transmitter checked cycle by cycle
// against a countdown model, plus a default-parameter instance sending one word.
module tb_transmitter;

  localparam int HD     = 1;
  localparam int GB     = 1;
  localparam int BC     = 2 * (HD + 1);
  localparam int TOTAL  = (32 + GB) * BC;
  localparam int GAPC   = GB * BC;
  localparam int WORD_D = 32 * 102;

  logic clk = 1'b0;
  logic reset;
  logic reset_d;

  always #5 clk = ~clk;

  transmitter_if bus();
  transmitter_if bus_d();

  transmitter #(.HALF_DIV(HD), .GAP_BITS(GB)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  transmitter dut_d (
    .clk(clk),
    .reset(reset_d),
    .bus(bus_d)
  );

  int checks = 0;
  int fails  = 0;
  int words_done = 0;
  logic mon_en = 1'b0;

  logic [31:0] exp_q[$];
  int busy_left = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word occupies the transmitter for a fixed number of cycles after acceptance.
  always @(posedge clk) begin
    if (reset) begin
      busy_left = 0;
      exp_q.delete();
    end else if (busy_left == 0) begin
      if (bus.start) begin
        exp_q.push_back(bus.txdata);
        busy_left = TOTAL;
      end
    end else begin
      busy_left--;
    end
  end

  logic [31:0] cur_word = '0;
  logic [31:0] cap_word = '0;
  logic prev_com  = 1'b0;
  logic prev_sclk = 1'b0;
  int   pos;
  logic in_word;

  always @(negedge clk) begin
    if (mon_en) begin
      in_word = (busy_left > GAPC);
      pos     = TOTAL - busy_left;
      checkOutput("ready", bus.ready, busy_left == 0);
      checkOutput("busy", bus.busy, busy_left != 0);
      checkOutput("comEn", bus.comEn, in_word);
      checkOutput("done", bus.done, busy_left == GAPC);
      checkOutput("sclk", bus.sclk, in_word && ((pos % BC) >= BC / 2));
      if (bus.comEn && !prev_com) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL frame: got unexpected frame expected none at %0t", $time);
        end else begin
          cur_word = exp_q.pop_front();
        end
        cap_word = '0;
      end
      if (in_word)
        checkOutput("dataout", bus.dataout, cur_word[31 - pos / BC]);
      else
        checkOutput("dataout_idle", bus.dataout, 1'b0);
      if (bus.comEn && bus.sclk && !prev_sclk)
        cap_word = {cap_word[30:0], bus.dataout};
      if (bus.done) begin
        checkOutput("word", cap_word, cur_word);
        words_done++;
      end
      prev_com  = bus.comEn;
      prev_sclk = bus.sclk;
    end
  end

  int d_cycle = 0;
  int d_rise  = -1;
  int d_high  = 0;
  int d_done  = 0;
  logic [31:0] d_cap = '0;
  logic d_prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      d_cycle++;
      if (bus_d.comEn) begin
        if (d_rise < 0) d_rise = d_cycle;
        d_high++;
        if (bus_d.sclk && !d_prev_sclk) d_cap = {d_cap[30:0], bus_d.dataout};
      end
      if (bus_d.done) begin
        d_done++;
        checkOutput("dflt_done_time", d_cycle - d_rise, WORD_D);
        checkOutput("dflt_word", d_cap, 32'hA5A5_0F0F);
      end
      d_prev_sclk = bus_d.sclk;
    end
  end

  task automatic applyStimulus(input logic [31:0] data, input int hold);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.txdata = data;
    repeat (hold) @(negedge clk);
    bus.start  = 1'b0;
    bus.txdata = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    reset_d = 1'b1;
    bus.start = 1'b0;
    bus.txdata = '0;
    bus_d.start = 1'b0;
    bus_d.txdata = '0;
    idle(2);
    mon_en = 1'b1;
    checkOutput("rst_ready_d", bus_d.ready, 1'b1);
    checkOutput("rst_busy_d", bus_d.busy, 1'b0);
    checkOutput("rst_comEn_d", bus_d.comEn, 1'b0);
    checkOutput("rst_dataout_d", bus_d.dataout, 1'b0);
    checkOutput("rst_sclk_d", bus_d.sclk, 1'b0);
    checkOutput("rst_done_d", bus_d.done, 1'b0);
    reset = 1'b0;
    reset_d = 1'b0;

    @(negedge clk);
    bus_d.start = 1'b1;
    bus_d.txdata = 32'hA5A5_0F0F;
    @(negedge clk);
    bus_d.start = 1'b0;
    bus_d.txdata = 32'h0;

    applyStimulus(32'hA5A5_0F0F, 1);
    idle(TOTAL + 2);
    applyStimulus(32'h8000_0001, 1);
    idle(TOTAL + 2);

    // Starts during SHIFT and during GAP must not disturb the word in flight.
    applyStimulus(32'h1234_5678, 1);
    idle(20);
    applyStimulus(32'hFFFF_FFFF, 1);
    idle(106);
    applyStimulus(32'h0F0F_F0F0, 1);
    idle(10);

    // Held start: words repeat back to back with txdata changing every cycle.
    @(negedge clk);
    bus.start = 1'b1;
    for (int i = 0; i < 3 * TOTAL + 6; i++) begin
      bus.txdata = $urandom;
      @(negedge clk);
    end
    bus.start = 1'b0;
    idle(TOTAL + 2);

    // Abort at bit 10, then send a full word.
    applyStimulus(32'hCAFE_F00D, 1);
    idle(10 * BC + 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    applyStimulus(32'hDEAD_BEEF, 1);
    idle(TOTAL + 2);

    // Reset and start together: reset wins.
    @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b1;
    bus.txdata = 32'h5555_AAAA;
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
    idle(4);

    for (int i = 0; i < 15; i++) begin
      applyStimulus($urandom, $urandom_range(1, 3));
      idle($urandom_range(0, TOTAL + 20));
    end
    idle(TOTAL + 5);

    while (d_cycle < 3600) @(negedge clk);
    checkOutput("dflt_high", d_high, WORD_D);
    checkOutput("dflt_done_cnt", d_done, 1);
    checkOutput("dflt_ready_end", bus_d.ready, 1'b1);
    if (words_done < 8) begin
      checks++;
      fails++;
      $display("[TB] FAIL words: got %0d completed expected at least 8", words_done);
    end else begin
      checks++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/transmitter.md
TRANSMITTER -- requirements
Module: transmitter

Interface
REQ-001 Parameter HALF_DIV, default 50: half bit period is HALF_DIV+1 clk cycles; BIT_CYCLES = 2*(HALF_DIV+1), 102 at default.
REQ-002 Parameter GAP_BITS, default 2: number of idle bit periods with comEn low after each word; minimum 1.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 start  input  1  request to send txdata; accepted only while ready=1.
REQ-006 txdata  input  32  word to send; sampled only on the accepting cycle.
REQ-007 ready  output  1  high when idle and able to accept start.
REQ-008 busy  output  1  high from the cycle after acceptance until return to IDLE, including GAP.
REQ-009 done  output  1  one-cycle pulse when the 32nd bit period ends.
REQ-010 dataout  output  1  serial data, MSB first.
REQ-011 comEn  output  1  frame enable; high for exactly the 32 bit periods of a word.
REQ-012 sclk  output  1  bit clock; low for first half of each bit period, high for second half.

Function
REQ-013 States: IDLE, SHIFT, GAP. Registers: 32-bit shift register, 5-bit bit counter, divider counter 0..BIT_CYCLES-1, gap counter.
REQ-014 IDLE: ready=1, busy=0, comEn=0, dataout=0, sclk=0, done=0.
REQ-015 start=1 in IDLE: same edge loads txdata into shift register, clears bit and divider counters, and enters SHIFT; next cycle ready=0, busy=1, comEn=1, dataout=txdata[31].
REQ-016 start while not in IDLE is ignored, with no effect on the shift register or outputs.
REQ-017 SHIFT: dataout = shift register bit 31 at all times, so it changes only at bit-period boundaries.
REQ-018 SHIFT: sclk=1 when divider >= HALF_DIV+1, else 0; the sclk rising edge falls mid-bit while data is stable.
REQ-019 SHIFT, divider < BIT_CYCLES-1: divider increments.
REQ-020 SHIFT, divider = BIT_CYCLES-1 and bit counter < 31: divider goes to 0, bit counter increments, and the shift register shifts left by 1 with zero fill.
REQ-021 SHIFT, divider = BIT_CYCLES-1 and bit counter = 31: enter GAP and clear divider and gap counter; next cycle done=1 for exactly one cycle, comEn=0, dataout=0, sclk=0.
REQ-022 Word length is exactly 32*BIT_CYCLES cycles of comEn high: 3264 at default.
REQ-023 GAP: comEn=0, busy=1, ready=0, sclk=0; lasts GAP_BITS*BIT_CYCLES cycles, then enters IDLE.
REQ-024 Back-to-back words are not allowed: a start asserted during GAP is ignored, and a start held high across the GAP→IDLE boundary is accepted on the first IDLE cycle.
REQ-025 The bit counter does not wrap inside a word, and the divider wraps only as stated in REQ-020 and REQ-021.
REQ-026 The shift register is 32 bits wide; no arithmetic on it beyond the shift.

Reset
REQ-027 Reset=1 at posedge clk forces IDLE, clears all counters and the shift register, and sets ready=1, busy=0, done=0, comEn=0, dataout=0, sclk=0, regardless of state.
REQ-028 Reset mid-SHIFT aborts the word: comEn drops on the next cycle, no done pulse is produced, and no GAP is inserted.
REQ-029 Reset and start high together: reset wins and start is ignored that cycle.

Verification
REQ-030 Reset, then start with txdata=0xA5A5_0F0F at defaults -> comEn high 3264 cycles; dataout per bit period, MSB first, reads 1,0,1,0,0,1,0,1,...,1,1,1,1; done pulses once 3264 cycles after comEn rises.
REQ-031 HALF_DIV=1, GAP_BITS=1, txdata=0x8000_0001 -> BIT_CYCLES=4; sclk pattern 0,0,1,1 per bit; dataout=1 for bit 0, 0 for bits 1-30, 1 for bit 31; busy falls 4 cycles after done.
REQ-032 Start pulses during SHIFT and GAP with different txdata -> ignored; the transmitted word stays the originally accepted value.
REQ-033 Reset asserted at bit 10 of a word -> next cycle comEn=0, ready=1, no done pulse; a new start then sends a full 32-bit word correctly.
REQ-034 Loopback: transmitter dataout/comEn drive the team's receiver with matching HALF_DIV -> receiver raises dataRDY with data equal to txdata (0xDEADBEEF) within one bit period of done.
REQ-035 start held high continuously at HALF_DIV=1, GAP_BITS=1 -> words repeat every 128+4+1 cycles; done pulses are equally spaced.
